// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter for a two-input mux datapath.
// Drives sel and registers the chosen word into a one-entry output stage.
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] in0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] in1,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam int BW = CW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;

  logic             space;
  logic             xfer0;
  logic             xfer1;
  logic             xfer_cur;
  logic [BW-1:0]    beats;
  logic             burst_done;
  logic [CW-1:0]    cnt_sat;

  // Grant qualifiers and burst accounting for the current owner
  always_comb begin
    space      = !out_valid_q || out_ready;
    xfer0      = req0 && gnt0;
    xfer1      = req1 && gnt1;
    xfer_cur   = xfer0 || xfer1;
    beats      = {1'b0, cnt_q} + BW'(xfer_cur);
    burst_done = beats >= BW'(MAX_BURST);
    cnt_sat    = burst_done ? CW'(MAX_BURST)
                            : beats[CW-1:0];
  end

  // State, history and output-stage registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next owner: alternate on contention, bound bursts by MAX_BURST
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = last_q ? GRANT0 : GRANT1;
        end else if (req0) begin
          state_d = GRANT0;
        end else if (req1) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        if (!req0) begin
          state_d = req1 ? GRANT1 : IDLE;
        end else if (req1 && burst_done) begin
          state_d = GRANT1;
        end
      end
      GRANT1: begin
        if (!req1) begin
          state_d = req0 ? GRANT0 : IDLE;
        end else if (req0 && burst_done) begin
          state_d = GRANT0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_sat;
    end
    if (state_d == GRANT0 && state_q != GRANT0) begin
      last_d = 1'b0;
    end else if (state_d == GRANT1 && state_q != GRANT1) begin
      last_d = 1'b1;
    end
  end

  // Output stage: load on transfer, drain on consume
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (xfer0) begin
      out_d       = in0;
      out_valid_d = 1'b1;
    end else if (xfer1) begin
      out_d       = in1;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Grants and mux select decoded from the owner state
  always_comb begin
    gnt0      = (state_q == GRANT0) && space;
    gnt1      = (state_q == GRANT1) && space;
    sel       = (state_q == GRANT1);
    out       = out_q;
    out_valid = out_valid_q;
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter.
// Second instance runs with MAX_BURST=1.
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [7:0] in0, in1;
  logic       out_ready;

  logic       gnt0, gnt1, sel, out_valid;
  logic [7:0] dout;
  logic       gnt0_b, gnt1_b, sel_b, out_valid_b;
  logic [7:0] dout_b;

  int nchk  = 0;
  int npass = 0;

  logic [11:0] obs, obs_b;
  assign obs   = {out_valid, dout, gnt0, gnt1, sel};
  assign obs_b = {out_valid_b, dout_b, gnt0_b, gnt1_b, sel_b};

  mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .in0(in0), .gnt0(gnt0),
    .req1(req1), .in1(in1), .gnt1(gnt1),
    .sel(sel), .out(dout), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut_b (
    .clk(clk), .reset(reset),
    .req0(req0), .in0(in0), .gnt0(gnt0_b),
    .req1(req1), .in1(in1), .gnt1(gnt1_b),
    .sel(sel_b), .out(dout_b), .out_valid(out_valid_b),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] mk(
    input logic v, input logic [7:0] d,
    input logic g0, input logic g1, input logic s);
    return {v, d, g0, g1, s};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    in0 = 8'h00; in1 = 8'h00;
    out_ready = 1'b1;
    tick();
    nchk++;
    if (obs !== mk(0, 8'h00, 0, 0, 0))
      $display("FAIL reset_state got %h exp %h",
               obs, mk(0, 8'h00, 0, 0, 0));
    else npass++;
    reset = 1'b0;
  endtask

  task automatic test_contention;
    logic [11:0] exp [11];
    logic x0, x1;
    exp = '{mk(0, 8'h00, 1, 0, 0),
            mk(1, 8'hA0, 1, 0, 0),
            mk(1, 8'hA1, 1, 0, 0),
            mk(1, 8'hA2, 1, 0, 0),
            mk(1, 8'hA3, 0, 1, 1),
            mk(1, 8'hB0, 0, 1, 1),
            mk(1, 8'hB1, 0, 1, 1),
            mk(1, 8'hB2, 0, 1, 1),
            mk(1, 8'hB3, 1, 0, 0),
            mk(1, 8'hA4, 1, 0, 0),
            mk(0, 8'hA4, 0, 0, 0)};
    req0 = 1'b1; req1 = 1'b1;
    in0 = 8'hA0; in1 = 8'hB0;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      x0 = req0 && gnt0;
      x1 = req1 && gnt1;
      tick();
      if (x0) in0 = in0 + 8'h01;
      if (x1) in1 = in1 + 8'h01;
      nchk++;
      if (obs !== exp[i])
        $display("FAIL contention cyc%0d got %h exp %h",
                 i, obs, exp[i]);
      else npass++;
      if (i == 9) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
  endtask

  task automatic test_single;
    logic [11:0] exp [5];
    exp = '{mk(0, 8'hA4, 1, 0, 0),
            mk(1, 8'h11, 1, 0, 0),
            mk(1, 8'h22, 1, 0, 0),
            mk(1, 8'h33, 1, 0, 0),
            mk(0, 8'h33, 0, 0, 0)};
    req0 = 1'b1; in0 = 8'h11;
    for (int i = 0; i < 5; i++) begin
      tick();
      nchk++;
      if (obs !== exp[i])
        $display("FAIL single cyc%0d got %h exp %h",
                 i, obs, exp[i]);
      else npass++;
      if (i == 1) in0 = 8'h22;
      if (i == 2) in0 = 8'h33;
      if (i == 3) req0 = 1'b0;
    end
  endtask

  task automatic test_backpressure;
    logic [11:0] exp [7];
    exp = '{mk(0, 8'h33, 0, 1, 1),
            mk(1, 8'hC0, 0, 1, 1),
            mk(1, 8'hC0, 0, 0, 1),
            mk(1, 8'hC0, 0, 0, 1),
            mk(1, 8'hC0, 0, 0, 1),
            mk(1, 8'hC1, 0, 1, 1),
            mk(0, 8'hC1, 0, 0, 0)};
    req1 = 1'b1; in1 = 8'hC0;
    for (int i = 0; i < 7; i++) begin
      tick();
      nchk++;
      if (obs !== exp[i])
        $display("FAIL backpressure cyc%0d got %h exp %h",
                 i, obs, exp[i]);
      else npass++;
      if (i == 1) begin
        out_ready = 1'b0; in1 = 8'hC1;
      end
      if (i == 4) begin
        nchk++;
        if (dut.cnt_q !== 3'd1)
          $display("FAIL bp_cnt_frozen got %0d exp 1",
                   dut.cnt_q);
        else npass++;
        out_ready = 1'b1;
      end
      if (i == 5) req1 = 1'b0;
    end
  endtask

  task automatic test_early_drop;
    logic [11:0] exp [6];
    exp = '{mk(0, 8'hC1, 1, 0, 0),
            mk(1, 8'hD0, 1, 0, 0),
            mk(1, 8'hD1, 1, 0, 0),
            mk(0, 8'hD1, 0, 1, 1),
            mk(1, 8'hE0, 0, 1, 1),
            mk(0, 8'hE0, 0, 0, 0)};
    req0 = 1'b1; in0 = 8'hD0;
    req1 = 1'b1; in1 = 8'hE0;
    for (int i = 0; i < 6; i++) begin
      tick();
      nchk++;
      if (obs !== exp[i])
        $display("FAIL early_drop cyc%0d got %h exp %h",
                 i, obs, exp[i]);
      else npass++;
      if (i == 1) in0 = 8'hD1;
      if (i == 2) req0 = 1'b0;
      if (i == 3) begin
        nchk++;
        if (dut.cnt_q !== 3'd0)
          $display("FAIL drop_cnt got %0d exp 0", dut.cnt_q);
        else npass++;
      end
      if (i == 4) req1 = 1'b0;
    end
  endtask

  task automatic test_reset_midstream;
    logic [11:0] exp [6];
    exp = '{mk(0, 8'hE0, 1, 0, 0),
            mk(1, 8'hF0, 1, 0, 0),
            mk(0, 8'h00, 0, 0, 0),
            mk(0, 8'h00, 1, 0, 0),
            mk(1, 8'hF0, 1, 0, 0),
            mk(0, 8'hF0, 0, 0, 0)};
    req0 = 1'b1; in0 = 8'hF0;
    for (int i = 0; i < 6; i++) begin
      tick();
      nchk++;
      if (obs !== exp[i])
        $display("FAIL reset_mid cyc%0d got %h exp %h",
                 i, obs, exp[i]);
      else npass++;
      if (i == 1) begin
        out_ready = 1'b0; reset = 1'b1;
      end
      if (i == 2) begin
        reset = 1'b0; out_ready = 1'b1;
        req1 = 1'b1; in1 = 8'hF1;
      end
      if (i == 4) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
  endtask

  task automatic test_burst1;
    logic [11:0] exp [6];
    exp = '{mk(0, 8'h00, 1, 0, 0),
            mk(1, 8'h55, 0, 1, 1),
            mk(1, 8'h66, 1, 0, 0),
            mk(1, 8'h55, 0, 1, 1),
            mk(1, 8'h66, 1, 0, 0),
            mk(1, 8'h55, 0, 1, 1)};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1; in0 = 8'h55;
    req1 = 1'b1; in1 = 8'h66;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      nchk++;
      if (obs_b !== exp[i])
        $display("FAIL burst1 cyc%0d got %h exp %h",
                 i, obs_b, exp[i]);
      else npass++;
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_early_drop();
    test_reset_midstream();
    test_burst1();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Round-robin arbiter and sequencer for the two-input mux datapath: it shares one output channel between two requesters, drives the mux `sel`, and registers the selected word into a single-entry output stage with a valid/ready handshake. Bursts from one requester are bounded by `MAX_BURST` when the other requester is waiting. It sits between the requesters and the downstream consumer, replacing direct software control of `sel`.

## Interface
- `WIDTH`, 8, data width of `in0`, `in1`, `out`
- `MAX_BURST`, 4, consecutive transfers allowed while the other requester waits; ≥1
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req0`  in  1  requester 0 has a word on `in0`
- `in0`  in  WIDTH  requester 0 data; stable while `req0` high and not yet transferred
- `gnt0`  out  1  requester 0 granted; transfer when `req0 && gnt0`
- `req1`  in  1  requester 1 request
- `in1`  in  WIDTH  requester 1 data
- `gnt1`  out  1  requester 1 granted; transfer when `req1 && gnt1`
- `sel`  out  1  mux select: 1 in GRANT1, else 0
- `out`  out  WIDTH  registered output word
- `out_valid`  out  1  `out` holds an unconsumed word
- `out_ready`  in  1  downstream accepts `out` when `out_valid && out_ready`

## Operation
- States: IDLE, GRANT0, GRANT1 (registered). Also `last` (last granted requester, reset 1) and `cnt` (beats in current grant, 0..MAX_BURST, saturating).
- `space = !out_valid || out_ready`. `gnt0 = (state==GRANT0) && space`; `gnt1 = (state==GRANT1) && space`. Combinational from state and `out_valid`/`out_ready`.
- Transfer i (`xfer_i = req_i && gnt_i`): `out <= in_i`, `out_valid <= 1`. Otherwise, if `out_valid && out_ready`, `out_valid <= 0`; `out` holds.
- `beats = cnt + xfer` (current state's requester).
- IDLE: both req → GRANT of requester ≠ `last`; one req → that requester; none → stay.
- GRANTi, `!req_i`: `req_other` → GRANTother, else IDLE.
- GRANTi, `req_i && req_other && beats >= MAX_BURST` → GRANTother.
- GRANTi otherwise: stay; `cnt <= min(beats, MAX_BURST)`.
- Any state change: `cnt <= 0`. Entering GRANTi sets `last <= i`.
- Both requests never granted in the same cycle; `gnt0 && gnt1` is never 1.

## Timing
- Reset (synchronous, dominates all): state IDLE, `last`=1, `cnt`=0, `out`=0, `out_valid`=0, `gnt0`=`gnt1`=0, `sel`=0. An in-flight word in `out` is discarded; no transfer is taken in the reset cycle.
- Grant latency from IDLE: `req` sampled at edge k → gnt visible after edge k, transfer possible at edge k+1.
- Data latency: transfer at edge k → `out`/`out_valid` valid after edge k. Full throughput (one word per cycle) with `out_ready` held high.
- Switch between requesters: zero bubble cycles. The last beat of GRANTi and the state change occur on the same edge; GRANTother can transfer on the next edge.
- Stall (`out_valid && !out_ready`): gnts low, `out` held, `cnt` frozen, state held unless `req_i` drops.
- Simultaneous consume and new transfer on the same edge: `out` replaced, `out_valid` stays 1.
- `MAX_BURST`=1 with both requesting: strict alternation every cycle.
- Sole requester: never forced off; `cnt` saturates at `MAX_BURST`. Other request arriving then switches after the next transfer edge, or on the next edge if stalled (`beats >= MAX_BURST` already).

## Test plan
- Reset check: drive `reset`=1 mid-stream with `out_valid`=1 → after edge: `out_valid`=0, `out`=0, `gnt0`=`gnt1`=0, `sel`=0, IDLE. First grant after both req go high goes to requester 0.
- Single requester: `req0`=1, `in0`=0x11,0x22,0x33, `out_ready`=1 → `gnt0` one cycle after req; `out` = 0x11,0x22,0x33 on consecutive cycles; `sel`=0 throughout.
- Contention, `MAX_BURST`=4: both req held, `in0`=0xA*, `in1`=0xB* → `out` sequence A0,A1,A2,A3,B0,B1,B2,B3,A4… with no bubble; `sel` toggles every 4 transfers.
- Backpressure: `out_ready`=0 for 3 cycles during GRANT1 → `out` holds one value, `gnt1`=0, `cnt` frozen. On release, the word is consumed and the next transfer occurs on the same edge.
- Early drop: `req0` drops after 2 beats while `req1`=1 → GRANT1 on the next edge, `cnt`=0. Then `req1` drops with `req0`=0 → IDLE, gnts 0.
- `MAX_BURST`=1, both requesting → `out` alternates in0/in1 every cycle, `gnt0`/`gnt1` never both 1.
